// File: rtl/hps_pkg.sv
// Shared types and default constants for the HPS channel scheduler slice.
package hps_pkg;

   localparam int FRAME_LEN = 1024;
   localparam int DATA_W    = 24;
   localparam int MAX_W     = 48;

   typedef enum logic [2:0] {
      IDLE,
      FORWARD,
      WAIT_MAX,
      EMIT,
      ABORT
   } state_t;

   // Channel tag sits in the MSB of every result word.
   typedef struct packed {
      logic             ch;
      logic [MAX_W-1:0] max;
   } result_t;

endpackage

// File: rtl/hps_channel_scheduler_frame_beat_counter.sv
// Counts accepted beats of one spectrum stream modulo FRAME_LEN and flags frame start/end beats.
module frame_beat_counter #(
   parameter int FRAME_LEN = hps_pkg::FRAME_LEN
) (
   input  logic clk,
   input  logic reset,
   input  logic i_valid,
   output logic o_sof,
   output logic o_eof
);

   localparam int CNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

   logic [CNT_W-1:0] r_cnt;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt <= '0;
      end else if (i_valid) begin
         r_cnt <= (r_cnt == CNT_W'(FRAME_LEN - 1)) ? '0 : r_cnt + 1'b1;
      end
   end

   assign o_sof = i_valid && (r_cnt == '0);
   assign o_eof = i_valid && (r_cnt == CNT_W'(FRAME_LEN - 1));

endmodule

// File: rtl/hps_channel_scheduler.sv
// Shares one HPS engine between two spectrum channels, granting whole frames round-robin
// and tagging each HPS max with its channel; frames that cannot be granted are counted and dropped.
module hps_channel_scheduler #(
   parameter int FRAME_LEN = hps_pkg::FRAME_LEN,
   parameter int DATA_W    = hps_pkg::DATA_W,
   parameter int MAX_W     = hps_pkg::MAX_W,
   parameter int TIMEOUT   = 4096,
   parameter int DROP_W    = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_spec0_valid,
   input  logic [DATA_W-1:0] i_spec0_data,
   output logic              o_spec0_ready,
   input  logic              i_spec1_valid,
   input  logic [DATA_W-1:0] i_spec1_data,
   output logic              o_spec1_ready,
   output logic              o_hps_din_valid,
   output logic [DATA_W-1:0] o_hps_din_data,
   input  logic              i_hps_din_ready,
   input  logic              i_hps_max_valid,
   input  logic [MAX_W-1:0]  i_hps_max_data,
   output logic              o_hps_max_ready,
   output logic              o_hps_reset,
   output logic              o_result_valid,
   output logic [MAX_W:0]    o_result_data,
   input  logic              i_result_ready,
   output logic [DROP_W-1:0] o_drop0,
   output logic [DROP_W-1:0] o_drop1
);
   import hps_pkg::*;

   localparam int WC_W = $clog2(TIMEOUT + 1);

   state_t              r_state;
   logic                r_sel;
   logic                r_last_ch;
   logic [WC_W-1:0]     r_wait_cnt;
   logic                r_result_valid;
   logic                r_result_ch;
   logic [MAX_W-1:0]    r_result_max;
   logic                r_hps_reset;
   logic [DROP_W-1:0]   r_drop0;
   logic [DROP_W-1:0]   r_drop1;

   logic                w_sof0, w_eof0, w_sof1, w_eof1;
   logic                w_grant0, w_grant1, w_sel_eof;
   logic                w_din_valid;
   logic [DATA_W-1:0]   w_din_data;
   logic                w_unused;

   frame_beat_counter #(.FRAME_LEN(FRAME_LEN)) u_cnt0 (
      .clk     (clk),
      .reset   (reset),
      .i_valid (i_spec0_valid),
      .o_sof   (w_sof0),
      .o_eof   (w_eof0)
   );

   frame_beat_counter #(.FRAME_LEN(FRAME_LEN)) u_cnt1 (
      .clk     (clk),
      .reset   (reset),
      .i_valid (i_spec1_valid),
      .o_sof   (w_sof1),
      .o_eof   (w_eof1)
   );

   // On a simultaneous start the channel not served last wins.
   assign w_grant0  = (r_state == IDLE) && w_sof0 && (!w_sof1 || r_last_ch);
   assign w_grant1  = (r_state == IDLE) && w_sof1 && (!w_sof0 || !r_last_ch);
   assign w_sel_eof = r_sel ? w_eof1 : w_eof0;

   // NOTE: every combinational output gets a default first so no latch is inferred.
   always_comb begin
      w_din_valid = 1'b0;
      w_din_data  = '0;
      if (w_grant0 || (r_state == FORWARD && !r_sel)) begin
         w_din_valid = i_spec0_valid;
         w_din_data  = i_spec0_data;
      end else if (w_grant1 || (r_state == FORWARD && r_sel)) begin
         w_din_valid = i_spec1_valid;
         w_din_data  = i_spec1_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state        <= IDLE;
         r_sel          <= 1'b0;
         r_last_ch      <= 1'b1;
         r_wait_cnt     <= '0;
         r_result_valid <= 1'b0;
         r_result_ch    <= 1'b0;
         r_result_max   <= '0;
         r_hps_reset    <= 1'b0;
         r_drop0        <= '0;
         r_drop1        <= '0;
      end else begin
         if (w_sof0 && !w_grant0 && (r_drop0 != '1)) r_drop0 <= r_drop0 + 1'b1;
         if (w_sof1 && !w_grant1 && (r_drop1 != '1)) r_drop1 <= r_drop1 + 1'b1;

         case (r_state)
            IDLE: begin
               if (w_grant0 || w_grant1) begin
                  r_sel   <= w_grant1;
                  r_state <= FORWARD;
               end
            end
            FORWARD: begin
               if (w_sel_eof) begin
                  r_last_ch  <= r_sel;
                  r_wait_cnt <= '0;
                  r_state    <= WAIT_MAX;
               end
            end
            WAIT_MAX: begin
               if (i_hps_max_valid) begin
                  r_result_ch    <= r_sel;
                  r_result_max   <= i_hps_max_data;
                  r_result_valid <= 1'b1;
                  r_state        <= EMIT;
               end else if (r_wait_cnt == WC_W'(TIMEOUT - 1)) begin
                  r_hps_reset <= 1'b1;
                  r_wait_cnt  <= '0;
                  r_state     <= ABORT;
               end else begin
                  r_wait_cnt <= r_wait_cnt + 1'b1;
               end
            end
            EMIT: begin
               if (i_result_ready) begin
                  r_result_valid <= 1'b0;
                  r_state        <= IDLE;
               end
            end
            ABORT: begin
               // The wait counter is reused to hold the engine reset for two cycles.
               if (r_wait_cnt == WC_W'(1)) begin
                  r_hps_reset <= 1'b0;
                  r_state     <= IDLE;
               end else begin
                  r_wait_cnt <= r_wait_cnt + 1'b1;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   // The HPS engine is always ready, so its ready is deliberately left unused.
   assign w_unused        = i_hps_din_ready;

   assign o_spec0_ready   = 1'b1;
   assign o_spec1_ready   = 1'b1;
   assign o_hps_max_ready = 1'b1;
   assign o_hps_din_valid = w_din_valid;
   assign o_hps_din_data  = w_din_data;
   assign o_hps_reset     = r_hps_reset;
   assign o_result_valid  = r_result_valid;
   assign o_result_data   = {r_result_ch, r_result_max};
   assign o_drop0         = r_drop0;
   assign o_drop1         = r_drop1;

endmodule
